// File: rtl/add_scheduler_if.sv
// Bundle of the requester, adder and response handshakes around add_scheduler.
// master = scheduler side, slave = clients/adder/response-consumer side.
interface add_scheduler_if #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 8,
  parameter int ID_W    = $clog2(NUM_REQ)
);
  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ-1:0]        req_ready;
  logic [NUM_REQ*DATA_W-1:0] req_a;
  logic [NUM_REQ*DATA_W-1:0] req_b;

  logic [DATA_W-1:0]         add_a_data;
  logic [DATA_W-1:0]         add_b_data;
  logic                      add_a_valid;
  logic                      add_b_valid;
  logic                      add_a_ready;
  logic                      add_b_ready;
  logic [DATA_W:0]           add_o_data;
  logic                      add_o_valid;
  logic                      add_o_ready;

  logic                      rsp_valid;
  logic                      rsp_ready;
  logic [ID_W-1:0]           rsp_id;
  logic [DATA_W:0]           rsp_data;

  modport master (
    input  req_valid, req_a, req_b,
    input  add_a_ready, add_b_ready, add_o_data, add_o_valid,
    input  rsp_ready,
    output req_ready,
    output add_a_data, add_b_data, add_a_valid, add_b_valid, add_o_ready,
    output rsp_valid, rsp_id, rsp_data
  );

  modport slave (
    output req_valid, req_a, req_b,
    output add_a_ready, add_b_ready, add_o_data, add_o_valid,
    output rsp_ready,
    input  req_ready,
    input  add_a_data, add_b_data, add_a_valid, add_b_valid, add_o_ready,
    input  rsp_valid, rsp_id, rsp_data
  );
endinterface

// File: rtl/add_scheduler.sv
// Round-robin scheduler sharing one registered adder among NUM_REQ requesters;
// one operation in flight, result returned tagged with the requester ID.
module add_scheduler #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 8,
  parameter int ID_W    = $clog2(NUM_REQ),
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  add_scheduler_if.master  bus,
  output logic             busy,
  output logic [CNT_W-1:0] op_count,
  output logic             err_unexp,
  output logic [1:0]       dbg_state_o
);
  // Handshakes: a transfer happens on a rising edge where valid and ready are
  // both high; valid never waits on ready, and payload is held while valid is
  // high without ready.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_e;

  state_e            state_q, state_d;
  logic [ID_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [ID_W-1:0]   id_q, id_d;
  logic [DATA_W-1:0] a_q, a_d;
  logic [DATA_W-1:0] b_q, b_d;
  logic [DATA_W:0]   rsp_data_q, rsp_data_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              err_q, err_d;

  logic              any_valid;
  logic [ID_W-1:0]   sel;
  logic [ID_W-1:0]   sel_next;
  logic [DATA_W-1:0] a_sel;
  logic [DATA_W-1:0] b_sel;
  logic [NUM_REQ-1:0] grant;
  logic              issue_a_valid;
  logic              issue_b_valid;
  logic              issue_o_ready;
  logic              rsp_valid_c;

  // Search starts at rr_ptr and wraps modulo NUM_REQ (not necessarily a power of 2).
  always_comb begin
    int idx;
    logic [ID_W-1:0] idx_w;
    any_valid = 1'b0;
    sel       = rr_ptr_q;
    idx       = 0;
    idx_w     = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = int'(rr_ptr_q) + k;
      if (idx >= NUM_REQ) begin
        idx = idx - NUM_REQ;
      end
      idx_w = ID_W'(idx);
      if (!any_valid && bus.req_valid[idx_w]) begin
        any_valid = 1'b1;
        sel       = idx_w;
      end
    end
  end

  always_comb begin
    a_sel = '0;
    b_sel = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (ID_W'(i) == sel) begin
        a_sel = bus.req_a[i*DATA_W +: DATA_W];
        b_sel = bus.req_b[i*DATA_W +: DATA_W];
      end
    end
  end

  assign sel_next = (int'(sel) == NUM_REQ - 1) ? '0 : sel + 1'b1;

  always_comb begin
    state_d       = state_q;
    rr_ptr_d      = rr_ptr_q;
    id_d          = id_q;
    a_d           = a_q;
    b_d           = b_q;
    rsp_data_d    = rsp_data_q;
    cnt_d         = cnt_q;
    // A result pulse anywhere but WAIT is a protocol error of the adder.
    err_d         = err_q | (bus.add_o_valid && (state_q != WAIT));
    grant         = '0;
    issue_a_valid = 1'b0;
    issue_b_valid = 1'b0;
    issue_o_ready = 1'b0;
    rsp_valid_c   = 1'b0;
    case (state_q)
      IDLE: begin
        if (any_valid) begin
          grant    = NUM_REQ'(1) << sel;
          a_d      = a_sel;
          b_d      = b_sel;
          id_d     = sel;
          rr_ptr_d = sel_next;
          state_d  = ISSUE;
        end
      end
      ISSUE: begin
        issue_a_valid = 1'b1;
        issue_b_valid = 1'b1;
        issue_o_ready = 1'b1;
        // Both operand handshakes must complete together.
        if (bus.add_a_ready && bus.add_b_ready) begin
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (bus.add_o_valid) begin
          rsp_data_d = bus.add_o_data;
          state_d    = RESP;
        end
      end
      RESP: begin
        rsp_valid_c = 1'b1;
        if (bus.rsp_ready) begin
          cnt_d   = cnt_q + 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      rr_ptr_q   <= '0;
      id_q       <= '0;
      a_q        <= '0;
      b_q        <= '0;
      rsp_data_q <= '0;
      cnt_q      <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      id_q       <= id_d;
      a_q        <= a_d;
      b_q        <= b_d;
      rsp_data_q <= rsp_data_d;
      cnt_q      <= cnt_d;
      err_q      <= err_d;
    end
  end

  assign bus.req_ready   = grant;
  assign bus.add_a_data  = a_q;
  assign bus.add_b_data  = b_q;
  assign bus.add_a_valid = issue_a_valid;
  assign bus.add_b_valid = issue_b_valid;
  assign bus.add_o_ready = issue_o_ready;
  assign bus.rsp_valid   = rsp_valid_c;
  assign bus.rsp_id      = id_q;
  assign bus.rsp_data    = rsp_data_q;

  assign busy        = (state_q != IDLE);
  assign op_count    = cnt_q;
  assign err_unexp   = err_q;
  assign dbg_state_o = state_q;
endmodule

// File: doc/add_scheduler.md
# add_scheduler

Round-robin scheduler that shares one registered 8-bit adder datapath among `NUM_REQ` requesters. Each requester offers an operand pair on a valid/ready port. The scheduler grants one requester, drives the adder's two operand handshakes and output-ready, captures the one-cycle result pulse, and returns the sum tagged with the requester ID. Exactly one operation is in flight at a time. The block sits between the client logic and the adder instance.

## Interface
- `NUM_REQ`, 4: number of requesters, 2..8.
- `DATA_W`, 8: operand width; the sum is `DATA_W+1` bits.
- `ID_W`, `$clog2(NUM_REQ)`: requester ID width.
- `CNT_W`, 16: completed-operation counter width.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `req_valid`  in  `NUM_REQ`  per-requester operand valid.
- `req_ready`  out  `NUM_REQ`  per-requester accept, one-hot or zero.
- `req_a`  in  `NUM_REQ*DATA_W`  operand A; requester i occupies slice `[i*DATA_W +: DATA_W]`.
- `req_b`  in  `NUM_REQ*DATA_W`  operand B; same packing as `req_a`.
- `add_a_data` / `add_b_data`  out  `DATA_W`  operands to the adder.
- `add_a_valid` / `add_b_valid`  out  1  operand valids to the adder.
- `add_a_ready` / `add_b_ready`  in  1  operand readys from the adder.
- `add_o_data`  in  `DATA_W+1`  adder sum.
- `add_o_valid`  in  1  adder result pulse, one cycle.
- `add_o_ready`  out  1  output-ready to the adder.
- `rsp_valid`  out  1  response valid.
- `rsp_ready`  in  1  response accept.
- `rsp_id`  out  `ID_W`  ID of the requester that owns the response.
- `rsp_data`  out  `DATA_W+1`  sum.
- `busy`  out  1  high in any state other than IDLE.
- `op_count`  out  `CNT_W`  completed responses; wraps modulo 2^`CNT_W`.
- `err_unexp`  out  1  sticky flag: `add_o_valid` arrived outside WAIT.

## Operation
- FSM states:
  - IDLE: arbitrate among `req_valid`.
    - Round-robin search starts at `rr_ptr` and selects the first i with `req_valid[i]`.
    - `req_ready[sel]` = 1 combinationally; all other bits 0.
    - On `req_valid[sel]`, capture `req_a` and `req_b` slices and `sel`, set `rr_ptr` = (sel+1) mod `NUM_REQ`, go to ISSUE.
    - With no request valid, stay in IDLE; `rr_ptr` is unchanged.
  - ISSUE: `add_a_valid` = `add_b_valid` = `add_o_ready` = 1; drive the captured operands.
    - Fire = `add_a_ready & add_b_ready`; both handshakes must complete in the same cycle.
    - On fire, go to WAIT. Otherwise hold, with operands stable.
  - WAIT: all adder valids and `add_o_ready` = 0.
    - On `add_o_valid`, capture `add_o_data` into `rsp_data` and go to RESP.
  - RESP: `rsp_valid` = 1.
    - On `rsp_ready`, increment `op_count` and go to IDLE.
- `req_ready` is all-zero in ISSUE, WAIT and RESP. No grant is issued while a response is pending.
- `rsp_id` and `rsp_data` stay stable while `rsp_valid` is high and `rsp_ready` is low.
- Arithmetic: the sum is the adder's full `DATA_W+1`-bit result, passed through unmodified; no truncation.
- `add_o_valid` seen in IDLE, ISSUE or RESP is ignored for data and sets `err_unexp`. Only reset clears `err_unexp`.

## Timing
- Reset values:
  - state IDLE, `rr_ptr` 0.
  - All of `req_ready`, `add_a_valid`, `add_b_valid`, `add_o_ready`, `rsp_valid`, `busy` and `err_unexp` are 0.
  - `rsp_id`, `rsp_data` and `op_count` are 0.
  - Operand registers are 0.
- Nominal flow:
  - Cycle 0: request accepted in IDLE.
  - Cycle 1: ISSUE; adder fires.
  - Cycle 2: WAIT; `add_o_valid` pulses and the result is captured.
  - Cycle 3: `rsp_valid` is high.
- Latency is 3 cycles from request accept to `rsp_valid`. Back-to-back throughput is one operation per 4 cycles with `rsp_ready` held high.
- Reset asserted mid-operation: all state clears immediately and the in-flight operation is dropped. No response is issued for it.
- The adder result pulse is never back-pressured; `add_o_ready` is high only in ISSUE.

## Test plan
- Single op, requester 2: A=8'hFF, B=8'h01 -> `rsp_valid` 3 cycles after accept, `rsp_id`=2, `rsp_data`=9'h100, `op_count`=1.
- All 4 requesters valid continuously, `rsp_ready`=1 -> grant order 0,1,2,3,0, each response 4 cycles apart, IDs match grant order.
- `rsp_ready` held low for 5 cycles during RESP -> `rsp_valid`, `rsp_id` and `rsp_data` stable; `req_ready`=0 throughout; completes on release.
- `add_a_ready` low for 3 cycles in ISSUE -> valids held, operands stable, no fire until both readys are high; response data correct.
- `rst_n` pulsed low during WAIT -> all outputs at reset values within that cycle; the next request gets `rsp_id` from `rr_ptr`=0 and no stale response appears.
- `add_o_valid` forced high in IDLE -> `err_unexp`=1 and sticky, no response issued, `op_count` unchanged.
